// File: rtl/vision_pkg.sv
// Shared types and pixel-pattern helper for the video stream blocks.
// AXIS_PATGEN_LINE_GAP_EN adds the GAP state used for inter-line idle cycles.
package vision_pkg;

    typedef enum logic [2:0] {
        PAT_SOLID      = 3'd0,
        PAT_H_RAMP     = 3'd1,
        PAT_V_RAMP     = 3'd2,
        PAT_CHECKER    = 3'd3,
        PAT_FRAME_RAMP = 3'd4
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1
`ifdef AXIS_PATGEN_LINE_GAP_EN
        , ST_GAP  = 2'd2
`endif
    } patgen_state_e;

    localparam int unsigned PIX_CALC_W = 16;

    // Full-width pixel value; callers truncate to their pixel width.
    function automatic logic [PIX_CALC_W-1:0] pattern_pixel(
        input pattern_e        pattern,
        input logic [15:0]     x,
        input logic [15:0]     y,
        input logic [15:0]     frame,
        input logic [15:0]     value
    );
        logic [PIX_CALC_W-1:0] pix;
        case (pattern)
            PAT_SOLID:      pix = value;
            PAT_H_RAMP:     pix = x;
            PAT_V_RAMP:     pix = y;
            PAT_CHECKER:    pix = (x[3] ^ y[3]) ? value : 16'd0;
            PAT_FRAME_RAMP: pix = x + y + frame;
            default:        pix = 16'd0;
        endcase
        return pix;
    endfunction

endpackage

// File: rtl/axis_pattern_source.sv
// AXI4-Stream synthetic video frame generator (tuser = SOF, tlast = EOL).
// Define AXIS_PATGEN_LINE_GAP_EN to add cfg_gap and idle cycles after each line.
module axis_pattern_source
    import vision_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WIDTH  = 1920,
    parameter int MAX_HEIGHT = 1080
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic [15:0]           cfg_width,
    input  logic [15:0]           cfg_height,
    input  logic [2:0]            cfg_pattern,
    input  logic [DATA_WIDTH-1:0] cfg_value,
    input  logic                  cfg_continuous,
    input  logic                  start,
    input  logic                  stop,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_count,
`ifdef AXIS_PATGEN_LINE_GAP_EN
    input  logic [7:0]            cfg_gap,
`endif
    output logic                  cfg_err
);

    localparam int X_W = (MAX_WIDTH  > 1) ? $clog2(MAX_WIDTH)  : 1;
    localparam int Y_W = (MAX_HEIGHT > 1) ? $clog2(MAX_HEIGHT) : 1;

    patgen_state_e         state_r, state_nxt_s;
    logic [X_W-1:0]        x_r, x_nxt_s, bx_s;
    logic [Y_W-1:0]        y_r, y_nxt_s, by_s;
    logic [15:0]           width_r, width_nxt_s;
    logic [15:0]           height_r, height_nxt_s;
    pattern_e              pattern_r, pattern_nxt_s, sel_pattern_s;
    logic [DATA_WIDTH-1:0] value_r, value_nxt_s, sel_value_s;
    logic                  continuous_r, continuous_nxt_s;
    logic                  stop_pending_r, stop_pending_nxt_s;
    logic [15:0]           frame_count_r, frame_count_nxt_s, bframe_s;
    logic                  frame_done_r, frame_done_nxt_s;
    logic                  cfg_err_r, cfg_err_nxt_s;
    logic                  busy_r;
    logic                  tvalid_r, tvalid_nxt_s;
    logic [DATA_WIDTH-1:0] tdata_r, tdata_nxt_s;
    logic                  tlast_r, tlast_nxt_s;
    logic                  tuser_r, tuser_nxt_s;
    logic [15:0]           sel_width_s;
    logic                  ld_beat_s, ld_frame_s;
    logic                  cfg_ok_s, xfer_s, eol_s, eof_s, stop_seen_s;
    patgen_state_e         line_state_s;
    logic                  line_valid_s;
`ifdef AXIS_PATGEN_LINE_GAP_EN
    logic [7:0]            gap_cnt_r;
`endif

    assign cfg_ok_s    = (cfg_width  != 16'd0) && (cfg_width  <= 16'(MAX_WIDTH)) &&
                         (cfg_height != 16'd0) && (cfg_height <= 16'(MAX_HEIGHT));
    assign xfer_s      = tvalid_r & m_axis_tready;
    assign eol_s       = (16'(x_r) == (width_r - 16'd1));
    assign eof_s       = eol_s && (16'(y_r) == (height_r - 16'd1));
    assign stop_seen_s = stop_pending_r | stop;

    // State and valid to use after a tlast transfer that continues streaming.
    always_comb begin
`ifdef AXIS_PATGEN_LINE_GAP_EN
        line_state_s = (cfg_gap != 8'd0) ? ST_GAP : ST_ACTIVE;
        line_valid_s = (cfg_gap == 8'd0);
`else
        line_state_s = ST_ACTIVE;
        line_valid_s = 1'b1;
`endif
    end

    // Next-state, counters and next output beat.
    always_comb begin
        state_nxt_s       = state_r;
        x_nxt_s           = x_r;
        y_nxt_s           = y_r;
        width_nxt_s       = width_r;
        height_nxt_s      = height_r;
        pattern_nxt_s     = pattern_r;
        value_nxt_s       = value_r;
        continuous_nxt_s  = continuous_r;
        frame_count_nxt_s = frame_count_r;
        frame_done_nxt_s  = 1'b0;
        cfg_err_nxt_s     = cfg_err_r;
        tvalid_nxt_s      = tvalid_r;
        tdata_nxt_s       = tdata_r;
        tlast_nxt_s       = tlast_r;
        tuser_nxt_s       = tuser_r;
        ld_beat_s         = 1'b0;
        ld_frame_s        = 1'b0;
        bx_s              = {X_W{1'b0}};
        by_s              = {Y_W{1'b0}};
        bframe_s          = frame_count_r;
        case (state_r)
            ST_IDLE: begin
                if (start && cfg_ok_s) begin
                    state_nxt_s  = ST_ACTIVE;
                    tvalid_nxt_s = 1'b1;
                    ld_frame_s   = 1'b1;
                    ld_beat_s    = 1'b1;
                end else if (start) begin
                    cfg_err_nxt_s = 1'b1;
                end else begin
                    tvalid_nxt_s = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (xfer_s && eof_s) begin
                    frame_done_nxt_s  = 1'b1;
                    frame_count_nxt_s = frame_count_r + 16'd1;
                    if (continuous_r && !stop_seen_s && cfg_ok_s) begin
                        state_nxt_s  = line_state_s;
                        tvalid_nxt_s = line_valid_s;
                        ld_frame_s   = 1'b1;
                        ld_beat_s    = 1'b1;
                        bframe_s     = frame_count_r + 16'd1;
                    end else begin
                        // A bad config on a continuous resample ends the run.
                        state_nxt_s   = ST_IDLE;
                        tvalid_nxt_s  = 1'b0;
                        tdata_nxt_s   = {DATA_WIDTH{1'b0}};
                        tlast_nxt_s   = 1'b0;
                        tuser_nxt_s   = 1'b0;
                        x_nxt_s       = {X_W{1'b0}};
                        y_nxt_s       = {Y_W{1'b0}};
                        cfg_err_nxt_s = cfg_err_r | (continuous_r & ~stop_seen_s);
                    end
                end else if (xfer_s && eol_s) begin
                    state_nxt_s  = line_state_s;
                    tvalid_nxt_s = line_valid_s;
                    ld_beat_s    = 1'b1;
                    by_s         = y_r + Y_W'(1'b1);
                end else if (xfer_s) begin
                    ld_beat_s = 1'b1;
                    bx_s      = x_r + X_W'(1'b1);
                    by_s      = y_r;
                end else begin
                    tvalid_nxt_s = 1'b1;
                end
            end
`ifdef AXIS_PATGEN_LINE_GAP_EN
            ST_GAP: begin
                if (gap_cnt_r <= 8'd1) begin
                    state_nxt_s  = ST_ACTIVE;
                    tvalid_nxt_s = 1'b1;
                end else begin
                    tvalid_nxt_s = 1'b0;
                end
            end
`endif
            default: begin
                state_nxt_s  = ST_IDLE;
                tvalid_nxt_s = 1'b0;
            end
        endcase

        sel_pattern_s = ld_frame_s ? pattern_e'(cfg_pattern) : pattern_r;
        sel_value_s   = ld_frame_s ? cfg_value : value_r;
        sel_width_s   = ld_frame_s ? cfg_width : width_r;
        if (ld_frame_s) begin
            width_nxt_s      = cfg_width;
            height_nxt_s     = cfg_height;
            pattern_nxt_s    = pattern_e'(cfg_pattern);
            value_nxt_s      = cfg_value;
            continuous_nxt_s = cfg_continuous;
        end else begin
            width_nxt_s = width_r;
        end
        if (ld_beat_s) begin
            x_nxt_s     = bx_s;
            y_nxt_s     = by_s;
            tdata_nxt_s = DATA_WIDTH'(pattern_pixel(sel_pattern_s, 16'(bx_s), 16'(by_s),
                                                    bframe_s, 16'(sel_value_s)));
            tlast_nxt_s = (16'(bx_s) == (sel_width_s - 16'd1));
            tuser_nxt_s = (bx_s == {X_W{1'b0}}) && (by_s == {Y_W{1'b0}});
        end else begin
            x_nxt_s = x_r;
        end
        stop_pending_nxt_s = (state_r != ST_IDLE) && (state_nxt_s != ST_IDLE) && stop_seen_s;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counters, sampled configuration and registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r            <= {X_W{1'b0}};
            y_r            <= {Y_W{1'b0}};
            width_r        <= 16'd0;
            height_r       <= 16'd0;
            pattern_r      <= PAT_SOLID;
            value_r        <= {DATA_WIDTH{1'b0}};
            continuous_r   <= 1'b0;
            stop_pending_r <= 1'b0;
            frame_count_r  <= 16'd0;
            frame_done_r   <= 1'b0;
            cfg_err_r      <= 1'b0;
            busy_r         <= 1'b0;
            tvalid_r       <= 1'b0;
            tdata_r        <= {DATA_WIDTH{1'b0}};
            tlast_r        <= 1'b0;
            tuser_r        <= 1'b0;
        end else begin
            x_r            <= x_nxt_s;
            y_r            <= y_nxt_s;
            width_r        <= width_nxt_s;
            height_r       <= height_nxt_s;
            pattern_r      <= pattern_nxt_s;
            value_r        <= value_nxt_s;
            continuous_r   <= continuous_nxt_s;
            stop_pending_r <= stop_pending_nxt_s;
            frame_count_r  <= frame_count_nxt_s;
            frame_done_r   <= frame_done_nxt_s;
            cfg_err_r      <= cfg_err_nxt_s;
            busy_r         <= (state_nxt_s != ST_IDLE);
            tvalid_r       <= tvalid_nxt_s;
            tdata_r        <= tdata_nxt_s;
            tlast_r        <= tlast_nxt_s;
            tuser_r        <= tuser_nxt_s;
        end
    end

`ifdef AXIS_PATGEN_LINE_GAP_EN
    // Gap length tracks cfg_gap until the GAP state starts counting it down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt_r <= 8'd0;
        end else if (state_r == ST_GAP) begin
            gap_cnt_r <= gap_cnt_r - 8'd1;
        end else begin
            gap_cnt_r <= cfg_gap;
        end
    end
`endif

    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tlast  = tlast_r;
    assign m_axis_tuser  = tuser_r;
    assign busy          = busy_r;
    assign frame_done    = frame_done_r;
    assign frame_count   = frame_count_r;
    assign cfg_err       = cfg_err_r;

endmodule

// File: tb/tb_axis_pattern_source.sv
// Scoreboard bench for axis_pattern_source: a frame model queues expected beats,
// a monitor pops and compares each transfer.
module tb_axis_pattern_source;

    localparam int DW   = 8;
    localparam int MAXW = 1920;
    localparam int MAXH = 1080;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic [15:0]   cfg_width = 16'd0;
    logic [15:0]   cfg_height = 16'd0;
    logic [2:0]    cfg_pattern = 3'd0;
    logic [DW-1:0] cfg_value = 8'd0;
    logic          cfg_continuous = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic          cfg_err;
`ifdef AXIS_PATGEN_LINE_GAP_EN
    logic [7:0]    cfg_gap = 8'd0;
`endif

    axis_pattern_source #(.DATA_WIDTH(DW), .MAX_WIDTH(MAXW), .MAX_HEIGHT(MAXH)) dut (
        .clk(clk), .rst(rst),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_pattern(cfg_pattern),
        .cfg_value(cfg_value), .cfg_continuous(cfg_continuous),
        .start(start), .stop(stop), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count),
`ifdef AXIS_PATGEN_LINE_GAP_EN
        .cfg_gap(cfg_gap),
`endif
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
        logic          eof;
    } beat_t;

    beat_t         exp_q[$];
    int            xfer_cyc_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            model_frames = 0;
    int            xfer_cnt = 0;
    int            cyc = 0;
    int            tready_mode = 0;
    logic          exp_done = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW+1:0] prev_beat = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference pixel straight from the pattern definitions.
    function automatic logic [DW-1:0] model_pix(int pat, int x, int y, int fc, int val);
        int v;
        case (pat)
            0:       v = val;
            1:       v = x;
            2:       v = y;
            3:       v = ((((x / 8) + (y / 8)) % 2) == 1) ? val : 0;
            4:       v = x + y + fc;
            default: v = 0;
        endcase
        return DW'(v % 256);
    endfunction

    task automatic push_frame(int w, int h, int pat, int val);
        beat_t b;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                b.data = model_pix(pat, x, y, model_frames, val);
                b.user = (x == 0) && (y == 0);
                b.last = (x == w - 1);
                b.eof  = (x == w - 1) && (y == h - 1);
                exp_q.push_back(b);
            end
        end
        model_frames++;
    endtask

    task automatic set_cfg(int w, int h, int pat, int val, logic cont);
        cfg_width      = 16'(w);
        cfg_height     = 16'(h);
        cfg_pattern    = 3'(pat);
        cfg_value      = DW'(val);
        cfg_continuous = cont;
    endtask

    task automatic pulse_start(input logic expect_valid);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("tvalid_after_start", m_axis_tvalid, expect_valid);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_idle_timeout"}, busy, 1'b0);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic run_frame(int w, int h, int pat, int val);
        set_cfg(w, h, pat, val, 1'b0);
        push_frame(w, h, pat, val);
        pulse_start(1'b1);
        wait_idle("frame");
        chk("frame_count", frame_count, model_frames);
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst = 1'b1;
        exp_q.delete();
        model_frames = 0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Tready driver: 0 always ready, 1 toggling, otherwise random ~70% ready.
    initial begin
        forever begin
            @(posedge clk); #1;
            case (tready_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = ($urandom_range(0, 99) < 70);
            endcase
        end
    end

    // Monitor: pops expected beats on each transfer and checks handshake rules.
    always @(negedge clk) begin
        beat_t b;
        cyc++;
        if (rst) begin
            exp_done   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("frame_done_timing", frame_done, exp_done);
`ifndef AXIS_PATGEN_LINE_GAP_EN
            chk("busy_matches_tvalid", m_axis_tvalid, busy);
`endif
            if (prev_stall) begin
                chk("stall_tvalid_held", m_axis_tvalid, 1'b1);
                chk("stall_beat_held", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, prev_beat);
            end
            exp_done = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                xfer_cnt++;
                xfer_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data 0x%0h last %0b user %0b, expected no beat",
                             m_axis_tdata, m_axis_tlast, m_axis_tuser);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data_last_user", {m_axis_tdata, m_axis_tlast, m_axis_tuser},
                        {b.data, b.last, b.user});
                    exp_done = b.eof;
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tvalid", m_axis_tvalid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_outputs", {m_axis_tdata, m_axis_tlast, m_axis_tuser, frame_done, cfg_err}, 32'd0);
        chk("reset_frame_count", frame_count, 16'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // h-ramp 4x2, always ready, then toggled ready
        tready_mode = 0;
        run_frame(4, 2, 1, 0);
        tready_mode = 1;
        base = xfer_cnt;
        run_frame(4, 2, 1, 0);
        chk("toggle_transfer_count", xfer_cnt - base, 8);

        // random frames under random backpressure
        tready_mode = 2;
        repeat (8) begin
            run_frame($urandom_range(1, 20), $urandom_range(1, 10), $urandom_range(0, 4),
                      $urandom_range(0, 255));
        end
        run_frame(1, 3, 4, 0);
        run_frame(1, 1, 0, 8'h5a);

        // continuous frame ramp, stop ignored in IDLE, stop during frame 3
        do_reset();
        tready_mode = 0;
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        set_cfg(2, 2, 4, 0, 1'b1);
        push_frame(2, 2, 4, 0);
        push_frame(2, 2, 4, 0);
        push_frame(2, 2, 4, 0);
        base = xfer_cnt;
        pulse_start(1'b1);
        k = 0;
        while ((xfer_cnt - base) < 9 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("cont_reach_frame3", ((xfer_cnt - base) >= 9), 1'b1);
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_idle("cont");
        chk("cont_frame_count", frame_count, 16'd3);
        chk("cont_transfers", xfer_cnt - base, 12);
        cfg_continuous = 1'b0;

        // illegal configurations
        chk("cfg_err_clear_before", cfg_err, 1'b0);
        set_cfg(0, 2, 1, 0, 1'b0);
        pulse_start(1'b0);
        repeat (4) @(negedge clk);
        chk("bad_w_busy", busy, 1'b0);
        chk("bad_w_tvalid", m_axis_tvalid, 1'b0);
        chk("bad_w_cfg_err", cfg_err, 1'b1);
        set_cfg(4, MAXH + 1, 1, 0, 1'b0);
        pulse_start(1'b0);
        repeat (2) @(negedge clk);
        chk("bad_h_busy", busy, 1'b0);
        run_frame(4, 1, 2, 0);
        chk("cfg_err_sticky", cfg_err, 1'b1);
        do_reset();
        chk("cfg_err_cleared_by_rst", cfg_err, 1'b0);

        // asynchronous reset mid-line
        tready_mode = 0;
        set_cfg(8, 2, 1, 0, 1'b0);
        push_frame(8, 2, 1, 0);
        pulse_start(1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        exp_q.delete();
        model_frames = 0;
        #1;
        chk("async_rst_tvalid", m_axis_tvalid, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        run_frame(3, 2, 2, 0);

`ifdef AXIS_PATGEN_LINE_GAP_EN
        // three idle cycles after each tlast
        do_reset();
        cfg_gap = 8'd3;
        set_cfg(2, 2, 1, 0, 1'b0);
        push_frame(2, 2, 1, 0);
        xfer_cyc_q.delete();
        pulse_start(1'b1);
        wait_idle("gap");
        chk("gap_transfers", xfer_cyc_q.size(), 4);
        if (xfer_cyc_q.size() == 4) begin
            chk("gap_beat0_1", xfer_cyc_q[1] - xfer_cyc_q[0], 1);
            chk("gap_after_tlast", xfer_cyc_q[2] - xfer_cyc_q[1], 4);
            chk("gap_beat2_3", xfer_cyc_q[3] - xfer_cyc_q[2], 1);
        end else begin
            chk("gap_sequence_length", xfer_cyc_q.size(), 4);
        end
        cfg_gap = 8'd0;
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
